rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
- Pipelined RV64I instruction encoder: the inverse of the instruction decoder. Accepts decoded fields (format, opcode, registers, functs, 64-bit sign-extended imm) over a valid/ready handshake, checks them, and packs each into a 32-bit instruction word.
- Each emitted word carries a sequential byte address, so the block can stream directly into instruction memory as a program loader or self-test generator.
- Illegal field combinations are dropped and reported. They never reach the output.

Parameters:
- XLEN, 64, width of imm, base_addr and out_addr.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  flush pipeline, load address counter from base_addr, clear err_count
- base_addr  in  XLEN  start address for the stream
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder accepts this cycle
- in_format  in  3  R=0 I=1 S=2 B=3 U=4 J=5; 6/7 illegal
- in_opcode  in  7  opcode[6:0]
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7
- in_imm  in  XLEN  sign-extended immediate, byte offset for B/J, full value for U
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded word
- out_addr  out  XLEN  address of out_instr
- err_valid  out  1  one-cycle pulse: an input was dropped
- err_code  out  2  0 none, 1 BAD_FORMAT, 2 IMM_RANGE, 3 IMM_ALIGN
- err_count  out  ERR_CNT_W  saturating count of dropped inputs

Behaviour:
- Reset (rst_n low at clk edge): both stage valids 0, out_valid 0, out_instr 0, out_addr 0, err_valid 0, err_code 0, err_count 0. Address counter is 0. Reset overrides start.
- Pipeline structure:
  - S1 registers the input fields and computes the error.
  - S2 holds the packed word and address, and drives the out_* ports.
  - Latency is 2 cycles from an accepted input to out_valid. Throughput is 1 per cycle.
- Handshakes:
  - Transfer occurs on in_valid && in_ready. in_ready = !s1_valid || s1_moves.
  - s1_moves = s1_err || !s2_valid || out_ready. An errored S1 entry never stalls.
  - in_ready does not depend on in_valid.
  - out_* are held stable while out_valid && !out_ready.
- Format check:
  - format 6/7 → BAD_FORMAT.
  - The opcode must match the format:
    - R: 0110011 or 0111011
    - I: 0010011, 0000011, 1100111 or 0011011
    - S: 0100011
    - B: 1100011
    - U: 0110111 or 0010111
    - J: 1101111
  - A mismatch → BAD_FORMAT.
- Alignment check: B or J with imm[0]≠0, or U with imm[11:0]≠0 → IMM_ALIGN.
- Range check → IMM_RANGE when:
  - I/S: imm outside [-2048, 2047]
  - B: imm outside [-4096, 4094]
  - J: imm outside [-2^20, 2^20-2]
  - U: imm[63:31] not all equal
  - R ignores imm.
- Error precedence: BAD_FORMAT > IMM_ALIGN > IMM_RANGE.
- Packing (exact inverse of the decoder field map):
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op. Shift-immediate funct7 bits are supplied via imm[11:5].
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - Fields unused by a format are ignored.
- Error drop: when an errored S1 entry moves, it is discarded (S2 is not written).
  - Next cycle: err_valid=1 with its err_code. err_code returns to 0 when err_valid drops.
  - err_count increments and saturates at all-ones.
  - The address counter is unchanged.
- Addressing:
  - out_addr = address counter, latched into S2 on each good S1→S2 move.
  - The counter increments by 4 per good move and wraps modulo 2^XLEN.
- start (synchronous, one cycle):
  - Clears s1/s2 valid, so in-flight words are lost and out_valid is 0 next cycle.
  - Loads counter = base_addr and clears err_count.
  - An input offered in the same cycle is not accepted: in_ready is 0 during start.

Decomposition:
- rv_isa_pkg holds:
  - format_e (R..J, INVALID=7)
  - opcode localparams
  - err_code_e
  - imm range bound constants
  - This package is shared with the decoder.
- Sub-module rv_instr_pack: combinational fields→word packer plus error classifier, instantiated in S1/S2. The top level holds the handshake, address counter and error counter.

Test Plan:
- start with base_addr=0x1000, then send ADDI (fmt1, op 0010011, rd1, rs1 2, f3 0, imm -1) → 2 cycles later out_instr=0xFFF10093, out_addr=0x1000.
- Back-to-back ADD x3,x1,x2; SD x5,8(x2); BEQ x0,x0,-4; JAL x1,2048 with out_ready=1 → 0x002081B3, 0x00513423, 0xFE000EE3, 0x001000EF at addrs 0x1000/04/08/0C on consecutive cycles.
- B-type with imm=3, then a U-type with a valid imm and opcode 0110011 → err_valid pulses with codes 3 then 1, err_count=2, no out_valid, next good word is still at base_addr.
- out_ready=0 while 4 inputs are offered → in_ready drops after 2 are accepted, out_instr held stable; release → all 4 words emitted in order, none lost or duplicated.
- I-type imm=2048 → IMM_RANGE; I-type imm=-2048 → encodes imm field 0x800.
- start asserted with 2 words in flight → out_valid=0 next cycle, those words are never emitted, and new output starts at the new base_addr. Reset mid-stream behaves the same way and also zeroes the counter.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV64I encoding constants shared by the instruction encoder and decoder.
//   format_e    - instruction format selector (R, I, S, B, U, J; INVALID = 7)
//   OP_*        - base opcodes accepted for each format
//   err_code_e  - reasons an encode request is dropped
//   IMM_*_BITS  - signed immediate width of each format; the format's legal
//                 range is what fits in that many two's-complement bits
package rv_isa_pkg;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_INVALID = 3'd7
    } format_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_BAD_FORMAT = 2'd1,
        ERR_IMM_RANGE  = 2'd2,
        ERR_IMM_ALIGN  = 2'd3
    } err_code_e;

    // I/S: [-2048, 2047]; B: [-4096, 4094]; J: [-2^20, 2^20-2];
    // U: value must be representable in 32 signed bits.
    // The odd upper ends of B/J are already rejected by the alignment check.
    localparam int IMM_I_BITS = 12;
    localparam int IMM_S_BITS = 12;
    localparam int IMM_B_BITS = 13;
    localparam int IMM_J_BITS = 21;
    localparam int IMM_U_BITS = 32;

endpackage

// File: rtl/rv_instr_pack.sv
// rv_instr_pack: combinational packer and error classifier.
//   format, opcode, rd, rs1, rs2, funct3, funct7, imm : decoded fields
//   instr : packed 32-bit instruction word (meaningful only when err == ERR_NONE)
//   err   : BAD_FORMAT > IMM_ALIGN > IMM_RANGE, ERR_NONE when the fields are legal
import rv_isa_pkg::*;

module rv_instr_pack #(
    parameter int XLEN = 64
) (
    input  logic [2:0]      format,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] imm,
    output logic [31:0]     instr,
    output err_code_e       err
);

    // True when v is a sign extension of its low 'bits' bits, i.e. everything
    // from bit (bits-1) upward is a copy of the sign.
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int bits);
        logic [XLEN-1:0] top;
        top = XLEN'($signed(v) >>> (bits - 1));
        return (top == '0) || (top == '1);
    endfunction

    logic fmt_ok;
    logic align_bad;
    logic range_bad;

    always_comb begin
        fmt_ok    = 1'b0;
        align_bad = 1'b0;
        range_bad = 1'b0;
        instr     = '0;
        case (format_e'(format))
            FMT_R: begin
                fmt_ok = (opcode == OP_OP) || (opcode == OP_OP_32);
                instr  = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                fmt_ok    = (opcode == OP_IMM) || (opcode == OP_LOAD) ||
                            (opcode == OP_JALR) || (opcode == OP_IMM_32);
                range_bad = !fits_signed(imm, IMM_I_BITS);
                instr     = {imm[11:0], rs1, funct3, rd, opcode};
            end
            FMT_S: begin
                fmt_ok    = (opcode == OP_STORE);
                range_bad = !fits_signed(imm, IMM_S_BITS);
                instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            FMT_B: begin
                fmt_ok    = (opcode == OP_BRANCH);
                align_bad = imm[0];
                range_bad = !fits_signed(imm, IMM_B_BITS);
                instr     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            FMT_U: begin
                fmt_ok    = (opcode == OP_LUI) || (opcode == OP_AUIPC);
                align_bad = (imm[11:0] != 12'd0);
                range_bad = !fits_signed(imm, IMM_U_BITS);
                instr     = {imm[31:12], rd, opcode};
            end
            FMT_J: begin
                fmt_ok    = (opcode == OP_JAL);
                align_bad = imm[0];
                range_bad = !fits_signed(imm, IMM_J_BITS);
                instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            default: fmt_ok = 1'b0;
        endcase
    end

    always_comb begin
        if (!fmt_ok)        err = ERR_BAD_FORMAT;
        else if (align_bad) err = ERR_IMM_ALIGN;
        else if (range_bad) err = ERR_IMM_RANGE;
        else                err = ERR_NONE;
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: two-stage RV64I encoder streaming addressed instruction words.
//   clk, rst_n           : clock, synchronous active-low reset
//   start, base_addr     : flush pipeline, load address counter, clear err_count
//   in_valid/in_ready    : input handshake for decoded fields in_*
//   out_valid/out_ready  : output handshake for out_instr at out_addr
//   err_valid, err_code  : one-cycle pulse when an input is dropped, with reason
//   err_count            : saturating count of dropped inputs
//
// Handshakes: a transfer happens on a rising edge where valid && ready. ready never
// depends on valid on the same side. While out_valid && !out_ready, out_instr and
// out_addr are held. in_ready is low during start.
import rv_isa_pkg::*;

module rv_instr_encoder #(
    parameter int XLEN      = 64,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [XLEN-1:0]      base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_format,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [XLEN-1:0]      in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [XLEN-1:0]      out_addr,
    output logic                 err_valid,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Stage 1: registered input fields
    logic            s1_valid;
    logic [2:0]      s1_format;
    logic [6:0]      s1_opcode;
    logic [4:0]      s1_rd;
    logic [4:0]      s1_rs1;
    logic [4:0]      s1_rs2;
    logic [2:0]      s1_funct3;
    logic [6:0]      s1_funct7;
    logic [XLEN-1:0] s1_imm;

    // Stage 2 drives the out_* ports directly
    logic            s2_valid;
    logic [XLEN-1:0] addr_cnt;

    logic [31:0]     pack_instr;
    err_code_e       pack_err;
    logic            s1_err;
    logic            s1_moves;
    logic            accept;

    rv_instr_pack #(.XLEN(XLEN)) u_pack (
        .format (s1_format),
        .opcode (s1_opcode),
        .rd     (s1_rd),
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .funct3 (s1_funct3),
        .funct7 (s1_funct7),
        .imm    (s1_imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    // An errored entry is discarded rather than forwarded, so it never waits on S2.
    assign s1_err    = (pack_err != ERR_NONE);
    assign s1_moves  = s1_err || !s2_valid || out_ready;
    assign in_ready  = !start && (!s1_valid || s1_moves);
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_format <= '0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
            s2_valid  <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            addr_cnt  <= '0;
            err_valid <= 1'b0;
            err_code  <= 2'd0;
            err_count <= '0;
        end else if (start) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            addr_cnt  <= base_addr;
            err_valid <= 1'b0;
            err_code  <= 2'd0;
            err_count <= '0;
        end else begin
            // Stage 2: take a good word from S1, otherwise drain on out_ready
            if (s1_valid && s1_moves && !s1_err) begin
                s2_valid  <= 1'b1;
                out_instr <= pack_instr;
                out_addr  <= addr_cnt;
                addr_cnt  <= addr_cnt + XLEN'(4);
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end

            // Dropped entry: report for one cycle and count (saturating)
            if (s1_valid && s1_err) begin
                err_valid <= 1'b1;
                err_code  <= pack_err;
                if (err_count != {ERR_CNT_W{1'b1}}) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end else begin
                err_valid <= 1'b0;
                err_code  <= 2'd0;
            end

            // Stage 1
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_format <= in_format;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_funct3 <= in_funct3;
                s1_funct7 <= in_funct7;
                s1_imm    <= in_imm;
            end else if (s1_moves) begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: randomized and directed stimulus for rv_instr_encoder with a
// behavioural model, expected queues and a decoupled output/error monitor.
module tb_rv_instr_encoder;

    localparam int XLEN      = 64;
    localparam int ERR_CNT_W = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [XLEN-1:0]      base_addr;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_format;
    logic [6:0]           in_opcode;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic [XLEN-1:0]      in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic [XLEN-1:0]      out_addr;
    logic                 err_valid;
    logic [1:0]           err_code;
    logic [ERR_CNT_W-1:0] err_count;

    rv_instr_encoder #(.XLEN(XLEN), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_format (in_format),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_count (err_count)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [95:0] exp_q[$];   // {addr, instr}
    logic [1:0]  err_q[$];
    logic [63:0] model_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] fld(input logic [63:0] v, input int hi, input int lo);
        return (v >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
    endfunction

    function automatic logic [1:0] model_err(input logic [2:0] fmt, input logic [6:0] op,
                                             input logic [63:0] imm);
        longint s;
        bit ok;
        s = longint'(imm);
        case (fmt)
            3'd0: ok = op inside {7'b0110011, 7'b0111011};
            3'd1: ok = op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011};
            3'd2: ok = (op == 7'b0100011);
            3'd3: ok = (op == 7'b1100011);
            3'd4: ok = op inside {7'b0110111, 7'b0010111};
            3'd5: ok = (op == 7'b1101111);
            default: ok = 0;
        endcase
        if (!ok) return 2'd1;
        if ((fmt == 3'd3 || fmt == 3'd5) && (s % 2 != 0)) return 2'd3;
        if (fmt == 3'd4 && (s % 4096 != 0)) return 2'd3;
        case (fmt)
            3'd1, 3'd2: if (s < -2048 || s > 2047) return 2'd2;
            3'd3: if (s < -4096 || s > 4094) return 2'd2;
            3'd5: if (s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 2) return 2'd2;
            3'd4: if (s < -(64'sd1 << 31) || s > (64'sd1 << 31) - 1) return 2'd2;
            default: ;
        endcase
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_word(input logic [2:0] fmt, input logic [6:0] op,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [63:0] imm);
        logic [63:0] w;
        w = 64'(op);
        case (fmt)
            3'd0: w = w + (64'(rd) << 7) + (64'(f3) << 12) + (64'(rs1) << 15)
                        + (64'(rs2) << 20) + (64'(f7) << 25);
            3'd1: w = w + (64'(rd) << 7) + (64'(f3) << 12) + (64'(rs1) << 15)
                        + (fld(imm, 11, 0) << 20);
            3'd2: w = w + (fld(imm, 4, 0) << 7) + (64'(f3) << 12) + (64'(rs1) << 15)
                        + (64'(rs2) << 20) + (fld(imm, 11, 5) << 25);
            3'd3: w = w + (fld(imm, 11, 11) << 7) + (fld(imm, 4, 1) << 8) + (64'(f3) << 12)
                        + (64'(rs1) << 15) + (64'(rs2) << 20) + (fld(imm, 10, 5) << 25)
                        + (fld(imm, 12, 12) << 31);
            3'd4: w = w + (64'(rd) << 7) + (fld(imm, 31, 12) << 12);
            default: w = w + (64'(rd) << 7) + (fld(imm, 19, 12) << 12)
                        + (fld(imm, 11, 11) << 20) + (fld(imm, 10, 1) << 21)
                        + (fld(imm, 20, 20) << 31);
        endcase
        return w[31:0];
    endfunction

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [63:0] imm,
                        input bit use_kat, input logic [31:0] kat);
        int waited;
        logic [1:0] e;
        waited    = 0;
        in_valid  = 1'b1;
        in_format = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        #1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
            in_valid = 1'b0;
            return;
        end
        e = model_err(fmt, op, imm);
        if (e != 2'd0) begin
            err_q.push_back(e);
        end else begin
            exp_q.push_back({model_addr, use_kat ? kat : model_word(fmt, op, rd, rs1, rs2, f3, f7, imm)});
            model_addr = model_addr + 64'd4;
        end
        accepted++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [63:0] base);
        start     = 1'b1;
        base_addr = base;
        exp_q.delete();
        err_q.delete();
        model_addr = base;
        #1;
        check("start_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        check("drain_out_q", 64'(exp_q.size()), 64'd0);
        check("drain_err_q", 64'(err_q.size()), 64'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic        held;
        logic [31:0] h_instr;
        logic [63:0] h_addr;
        logic [95:0] e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n || start) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_instr", 64'(out_instr), 64'(h_instr));
                check("hold_addr", out_addr, h_addr);
            end
            held    = out_valid && !out_ready;
            h_instr = out_instr;
            h_addr  = out_addr;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: instr 0x%0h addr 0x%0h, required no word", out_instr, out_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("out_instr", 64'(out_instr), 64'(e[31:0]));
                    check("out_addr", out_addr, e[95:32]);
                end
            end
            if (err_valid) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_err: code %0d, required no error", err_code);
                end else begin
                    check("err_code", 64'(err_code), 64'(err_q.pop_front()));
                end
            end else begin
                check("err_code_idle", 64'(err_code), 64'd0);
            end
        end
    end

    // ---------------- random stimulus helpers ----------------
    function automatic logic [6:0] pick_op(input logic [2:0] fmt, input int k);
        case (fmt)
            3'd0: return (k % 2 == 0) ? 7'b0110011 : 7'b0111011;
            3'd1: case (k % 4)
                      0: return 7'b0010011;
                      1: return 7'b0000011;
                      2: return 7'b1100111;
                      default: return 7'b0011011;
                  endcase
            3'd2: return 7'b0100011;
            3'd3: return 7'b1100011;
            3'd4: return (k % 2 == 0) ? 7'b0110111 : 7'b0010111;
            default: return 7'b1101111;
        endcase
    endfunction

    longint bounds[15] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                           1048574, 1048576, -1048576, -1048578,
                           64'h7FFFF000, 64'h80000000, -64'sh80000000};

    function automatic logic [63:0] pick_imm();
        case ($urandom_range(0, 4))
            0: return 64'(longint'($urandom_range(0, 8191)) - 4096);
            1: return {$urandom, $urandom};
            2: return 64'(bounds[$urandom_range(0, 14)]);
            3: return 64'(longint'(int'($urandom))) & ~64'hFFF;
            default: return 64'((longint'($urandom_range(0, 2097151)) - 1048576)) & ~64'd1;
        endcase
    endfunction

    bit rnd_done;

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_format = '0;
        in_opcode = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm    = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_addr", out_addr, 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADDI x1, x2, -1 and its latency
        do_start(64'h1000);
        send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, -64'sd1, 1, 32'hFFF10093);
        #1;
        check("lat_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("lat_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        wait_drain();

        // Back-to-back ADD, SD, BEQ, JAL
        do_start(64'h1000);
        send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 1, 32'h002081B3);
        send(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd3, 7'd0, 64'd8, 1, 32'h00513423);
        send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd4, 1, 32'hFE000EE3);
        send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048, 1, 32'h001000EF);
        wait_drain();

        // Dropped inputs: misaligned branch, then opcode/format mismatch
        do_start(64'h2000);
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3, 0, 32'd0);
        send(3'd4, 7'b0110011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1000, 0, 32'd0);
        wait_drain();
        check("err_count_2", 64'(err_count), 64'd2);
        send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5, 0, 32'd0);
        wait_drain();

        // Backpressure: 4 offered with out_ready low
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                send(3'd1, 7'b0010011, 5'd10, 5'd1, 5'd0, 3'd0, 7'd0, 64'd1, 0, 32'd0);
                send(3'd1, 7'b0010011, 5'd11, 5'd1, 5'd0, 3'd0, 7'd0, 64'd2, 0, 32'd0);
                send(3'd1, 7'b0010011, 5'd12, 5'd1, 5'd0, 3'd0, 7'd0, 64'd3, 0, 32'd0);
                send(3'd1, 7'b0010011, 5'd13, 5'd1, 5'd0, 3'd0, 7'd0, 64'd4, 0, 32'd0);
            end
            begin
                logic [31:0] snap;
                repeat (4) @(negedge clk);
                #1;
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_accepted", 64'(accepted), 64'd2);
                snap = out_instr;
                repeat (3) @(negedge clk);
                #1;
                check("stall_stable", 64'(out_instr), 64'(snap));
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Immediate boundaries
        send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd2048, 0, 32'd0);
        send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, -64'sd2048, 1, 32'h80010093);
        send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd2047, 0, 32'd0);
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 64'd4094, 0, 32'd0);
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 64'd4096, 0, 32'd0);
        send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1048576, 0, 32'd0);
        send(3'd4, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 64'h80000000, 0, 32'd0);
        send(3'd4, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFFFFFF80000000, 0, 32'd0);
        send(3'd6, 7'b0110011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 0, 32'd0);
        wait_drain();

        // start with words in flight
        out_ready = 1'b0;
        send(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 64'd0, 0, 32'd0);
        send(3'd0, 7'b0110011, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 64'd0, 0, 32'd0);
        do_start(64'h3000);
        #1;
        check("start_flush", 64'(out_valid), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        send(3'd0, 7'b0111011, 5'd8, 5'd9, 5'd10, 3'd0, 7'h20, 64'd0, 0, 32'd0);
        wait_drain();

        // reset mid-stream
        out_ready = 1'b0;
        send(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 64'd0, 0, 32'd0);
        send(3'd0, 7'b0110011, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 64'd0, 0, 32'd0);
        rst_n = 1'b0;
        exp_q.delete();
        err_q.delete();
        model_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_out_addr", out_addr, 64'd0);
        check("rst2_err_count", 64'(err_count), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        send(3'd2, 7'b0100011, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, -64'sd16, 0, 32'd0);
        wait_drain();

        // Randomized traffic with random backpressure
        do_start({$urandom, $urandom} & ~64'd3);
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int r;
                    logic [2:0] fmt;
                    logic [6:0] op;
                    r   = $urandom_range(0, 15);
                    fmt = (r < 14) ? 3'(r % 6) : 3'(6 + (r & 1));
                    op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pick_op(fmt, $urandom_range(0, 3));
                    send(fmt, op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                         7'($urandom), pick_imm(), 0, 32'd0);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
